// File: rtl/dist_filter_pkg.sv
// ---------------------------------------------------------------------------
// dist_filter_pkg : shared widths, ring depth and FSM encoding  (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

package dist_filter_pkg;
  localparam int DIST_W     = 17;
  localparam int RING_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_WARM  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;
endpackage

`default_nettype wire

// File: rtl/distance_filter_if.sv
// ---------------------------------------------------------------------------
// distance_filter_if : sample-in / filtered-result-out bundle  (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

interface distance_filter_if #(
  parameter int DIST_W = dist_filter_pkg::DIST_W
) ();
  logic              valid_i;
  logic [DIST_W-1:0] distance_i;
  logic              clear_i;
  logic              valid_o;
  logic [DIST_W-1:0] distance_o;
  logic              stable_o;
  logic              outlier_o;

  modport master (
    output valid_i, distance_i, clear_i,
    input  valid_o, distance_o, stable_o, outlier_o
  );

  modport slave (
    input  valid_i, distance_i, clear_i,
    output valid_o, distance_o, stable_o, outlier_o
  );
endinterface

`default_nettype wire

// File: rtl/distance_median3.sv
// ---------------------------------------------------------------------------
// distance_median3 : combinational median of three samples  (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module distance_median3 #(
  parameter int DIST_W = dist_filter_pkg::DIST_W
) (
  input  logic [DIST_W-1:0] a_i,
  input  logic [DIST_W-1:0] b_i,
  input  logic [DIST_W-1:0] c_i,
  output logic [DIST_W-1:0] med_o
);
  logic [DIST_W-1:0] lo_ab;
  logic [DIST_W-1:0] hi_ab;
  logic [DIST_W-1:0] lo_hc;

  // median = max(min(a,b), min(max(a,b),c))
  always_comb begin
    lo_ab = (a_i < b_i) ? a_i : b_i;
    hi_ab = (a_i < b_i) ? b_i : a_i;
    lo_hc = (hi_ab < c_i) ? hi_ab : c_i;
    med_o = (lo_ab > lo_hc) ? lo_ab : lo_hc;
  end
endmodule

`default_nettype wire

// File: rtl/distance_filter.sv
// ---------------------------------------------------------------------------
// distance_filter : outlier reject, median-of-3, 4-deep average, stability  (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module distance_filter #(
  parameter int DIST_W     = dist_filter_pkg::DIST_W,
  parameter int MAX_DIST   = 30000,
  parameter int TOL        = 20,
  parameter int STABLE_N   = 8,
  parameter int MISS_LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  distance_filter_if.slave bus
);
  import dist_filter_pkg::*;

  localparam int SUM_W  = DIST_W + 2;
  localparam int STAB_W = $clog2(STABLE_N + 1);
  localparam int MISS_W = $clog2(MISS_LIMIT + 1);
  localparam int PTR_W  = $clog2(RING_DEPTH);
  localparam int RCNT_W = $clog2(RING_DEPTH + 1);
  localparam logic [DIST_W-1:0] MAX_V    = DIST_W'(MAX_DIST);
  localparam logic [DIST_W-1:0] TOL_V    = DIST_W'(TOL);
  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_N);
  localparam logic [RCNT_W-1:0] RING_FULL = RCNT_W'(RING_DEPTH);

  state_e              state_q, state_d;
  logic [DIST_W-1:0]   win_q [2];
  logic [DIST_W-1:0]   win_d [2];
  logic [1:0]          win_cnt_q, win_cnt_d;
  logic [DIST_W-1:0]   med_q, med_d;
  logic                med_vld_q, med_vld_d;
  logic [DIST_W-1:0]   ring_q [RING_DEPTH];
  logic [DIST_W-1:0]   ring_d [RING_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [RCNT_W-1:0]   ring_cnt_q, ring_cnt_d;
  logic [SUM_W-1:0]    sum_q, sum_d;
  logic                valid_o_q, valid_o_d;
  logic [DIST_W-1:0]   dist_o_q, dist_o_d;
  logic                stable_q, stable_d;
  logic                outlier_q, outlier_d;
  logic [STAB_W-1:0]   steady_cnt_q, steady_cnt_d;
  logic [MISS_W-1:0]   miss_cnt_q, miss_cnt_d;

  logic [DIST_W-1:0]   med_w;
  logic                sample_bad;
  logic                flush_req;
  logic [DIST_W-1:0]   evict;
  logic [SUM_W-1:0]    sum_next;
  logic [DIST_W-1:0]   avg;
  logic [DIST_W-1:0]   diff;

  // The incoming sample plus the two held ones form the 3-entry raw window.
  distance_median3 #(.DIST_W(DIST_W)) u_median (
    .a_i   (bus.distance_i),
    .b_i   (win_q[0]),
    .c_i   (win_q[1]),
    .med_o (med_w)
  );

  assign sample_bad = (bus.distance_i == '0) || (bus.distance_i > MAX_V);

  always_comb begin
    state_d      = state_q;
    win_d        = win_q;
    win_cnt_d    = win_cnt_q;
    med_d        = med_q;
    med_vld_d    = 1'b0;
    ring_d       = ring_q;
    wr_ptr_d     = wr_ptr_q;
    ring_cnt_d   = ring_cnt_q;
    sum_d        = sum_q;
    sum_next     = sum_q;
    evict        = '0;
    avg          = dist_o_q;
    diff         = '0;
    dist_o_d     = dist_o_q;
    valid_o_d    = 1'b0;
    outlier_d    = 1'b0;
    stable_d     = stable_q;
    steady_cnt_d = steady_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    flush_req    = 1'b0;

    if (state_q == ST_FLUSH) begin
      state_d = bus.clear_i ? ST_FLUSH : ST_WARM;
    end else if (bus.clear_i) begin
      flush_req = 1'b1;
    end else begin
      if (bus.valid_i && sample_bad) begin
        outlier_d = 1'b1;
        if (miss_cnt_q == MISS_W'(MISS_LIMIT - 1)) flush_req = 1'b1;
        else                                       miss_cnt_d = miss_cnt_q + MISS_W'(1);
      end else if (bus.valid_i) begin
        miss_cnt_d = '0;
        win_d[0]   = bus.distance_i;
        win_d[1]   = win_q[0];
        if (win_cnt_q == 2'd2) begin
          med_vld_d = 1'b1;
          med_d     = med_w;
        end else begin
          win_cnt_d = win_cnt_q + 2'd1;
        end
      end

      if (med_vld_q) begin
        evict              = (ring_cnt_q == RING_FULL) ? ring_q[wr_ptr_q] : '0;
        sum_next           = sum_q + SUM_W'(med_q) - SUM_W'(evict);
        sum_d              = sum_next;
        ring_d[wr_ptr_q]   = med_q;
        wr_ptr_d           = wr_ptr_q + PTR_W'(1);
        if (ring_cnt_q != RING_FULL) ring_cnt_d = ring_cnt_q + RCNT_W'(1);
        if (ring_cnt_q >= RING_FULL - RCNT_W'(1)) begin
          avg       = sum_next[DIST_W+1:2];
          diff      = (avg >= dist_o_q) ? (avg - dist_o_q) : (dist_o_q - avg);
          valid_o_d = 1'b1;
          dist_o_d  = avg;
          state_d   = ST_RUN;
          // First result after warm-up is only the reference for the next one.
          if (state_q == ST_WARM)  steady_cnt_d = '0;
          else if (diff <= TOL_V) begin
            if (steady_cnt_q != STAB_MAX) steady_cnt_d = steady_cnt_q + STAB_W'(1);
          end else                 steady_cnt_d = '0;
          stable_d = (steady_cnt_d == STAB_MAX);
        end
      end
    end

    // Flush wins over any push this cycle, so no result escapes into FLUSH.
    if (flush_req) begin
      state_d      = ST_FLUSH;
      win_d        = '{default: '0};
      win_cnt_d    = '0;
      med_vld_d    = 1'b0;
      ring_d       = '{default: '0};
      wr_ptr_d     = '0;
      ring_cnt_d   = '0;
      sum_d        = '0;
      valid_o_d    = 1'b0;
      dist_o_d     = dist_o_q;
      stable_d     = 1'b0;
      steady_cnt_d = '0;
      miss_cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_WARM;
      win_q        <= '{default: '0};
      win_cnt_q    <= '0;
      med_q        <= '0;
      med_vld_q    <= 1'b0;
      ring_q       <= '{default: '0};
      wr_ptr_q     <= '0;
      ring_cnt_q   <= '0;
      sum_q        <= '0;
      valid_o_q    <= 1'b0;
      dist_o_q     <= '0;
      stable_q     <= 1'b0;
      outlier_q    <= 1'b0;
      steady_cnt_q <= '0;
      miss_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      win_q        <= win_d;
      win_cnt_q    <= win_cnt_d;
      med_q        <= med_d;
      med_vld_q    <= med_vld_d;
      ring_q       <= ring_d;
      wr_ptr_q     <= wr_ptr_d;
      ring_cnt_q   <= ring_cnt_d;
      sum_q        <= sum_d;
      valid_o_q    <= valid_o_d;
      dist_o_q     <= dist_o_d;
      stable_q     <= stable_d;
      outlier_q    <= outlier_d;
      steady_cnt_q <= steady_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  assign bus.valid_o    = valid_o_q;
  assign bus.distance_o = dist_o_q;
  assign bus.stable_o   = stable_q;
  assign bus.outlier_o  = outlier_q;
endmodule

`default_nettype wire

// File: tb/tb_distance_filter.sv
// ---------------------------------------------------------------------------
// tb_distance_filter : table, directed and random checks against a queue model  (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module tb_distance_filter;
  localparam int DW         = 17;
  localparam int MAX_DIST   = 30000;
  localparam int TOL        = 20;
  localparam int STABLE_N   = 8;
  localparam int MISS_LIMIT = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  distance_filter_if #(.DIST_W(DW)) bus ();

  distance_filter #(
    .DIST_W(DW), .MAX_DIST(MAX_DIST), .TOL(TOL),
    .STABLE_N(STABLE_N), .MISS_LIMIT(MISS_LIMIT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int    n_vec  = 0;
  int    n_miss = 0;
  string phase  = "init";

  // Reference model: accepted samples and medians kept as plain queues.
  int raw[$];
  int meds[$];
  bit pend;
  int pend_val;
  int miss;
  bit in_flush;
  bit have_ref;
  int steady;
  bit m_valid, m_stable, m_outlier;
  int m_dist;

  function automatic int med3(input int a, input int b, input int c);
    int q[$];
    q = {a, b, c};
    q.sort();
    return q[1];
  endfunction

  task automatic model_reset();
    raw.delete(); meds.delete();
    pend = 0; pend_val = 0; miss = 0; in_flush = 0; have_ref = 0; steady = 0;
    m_valid = 0; m_stable = 0; m_outlier = 0; m_dist = 0;
  endtask

  task automatic model_flush();
    raw.delete(); meds.delete();
    pend = 0; miss = 0; have_ref = 0; steady = 0; m_stable = 0; in_flush = 1;
  endtask

  task automatic model_deliver(input int val);
    int d;
    m_valid = 1;
    d = (val > m_dist) ? val - m_dist : m_dist - val;
    if (!have_ref) begin
      have_ref = 1; steady = 0;
    end else if (d <= TOL) begin
      if (steady < STABLE_N) steady++;
    end else begin
      steady = 0;
    end
    m_stable = (steady == STABLE_N);
    m_dist   = val;
  endtask

  // Inputs of cycle N -> expected outputs visible after the following edge.
  task automatic model_step(input bit v, input int d, input bit c);
    bit due;
    int due_val;
    due = pend; due_val = pend_val; pend = 0;
    m_valid = 0; m_outlier = 0;
    if (in_flush) begin
      in_flush = c;
    end else if (c) begin
      model_flush();
    end else begin
      if (v) begin
        if (d == 0 || d > MAX_DIST) begin
          m_outlier = 1;
          miss++;
          if (miss == MISS_LIMIT) model_flush();
        end else begin
          miss = 0;
          raw.push_back(d);
          if (raw.size() >= 3) begin
            meds.push_back(med3(raw[$], raw[$-1], raw[$-2]));
            if (meds.size() >= 4) begin
              pend     = 1;
              pend_val = (meds[$] + meds[$-1] + meds[$-2] + meds[$-3]) / 4;
            end
          end
        end
      end
      if (due && !in_flush) model_deliver(due_val);
    end
  endtask

  task automatic tick(input bit v, input int d, input bit c);
    @(negedge clk);
    bus.valid_i    = v;
    bus.distance_i = DW'(d);
    bus.clear_i    = c;
    model_step(v, d, c);
    @(posedge clk);
    #1;
  endtask

  task automatic check_model();
    n_vec++;
    if (bus.valid_o !== m_valid || bus.distance_o !== DW'(m_dist) ||
        bus.stable_o !== m_stable || bus.outlier_o !== m_outlier) begin
      n_miss++;
      $display("FAIL %s vec%0d: got v=%0b d=%0d s=%0b o=%0b, want v=%0b d=%0d s=%0b o=%0b",
               phase, n_vec, bus.valid_o, bus.distance_o, bus.stable_o, bus.outlier_o,
               m_valid, m_dist, m_stable, m_outlier);
    end
  endtask

  task automatic step(input bit v, input int d, input bit c);
    tick(v, d, c);
    check_model();
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s/%s: got %0d, want %0d", phase, nm, act, exp);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    bus.valid_i = 1'b0; bus.distance_i = '0; bus.clear_i = 1'b0;
    #1;
    model_reset();
    chk("rst_valid",   32'(bus.valid_o),    0);
    chk("rst_dist",    32'(bus.distance_o), 0);
    chk("rst_stable",  32'(bus.stable_o),   0);
    chk("rst_outlier", 32'(bus.outlier_o),  0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Six spaced samples: no result for the first five, result on the sixth.
  task automatic warm6(input int val, input string nm);
    for (int k = 1; k <= 6; k++) begin
      step(1, val, 0);
      step(0, 0, 0);
      chk(nm, 32'(bus.valid_o), (k == 6) ? 1 : 0);
    end
    chk({nm, "_dist"}, 32'(bus.distance_o), 32'(val));
  endtask

  typedef struct {
    bit v; int d; bit c;
    bit ev; int ed; bit es; bit eo;
  } vec_t;

  vec_t tbl[12];
  int   ramp_exp[12] = '{0, 0, 0, 0, 0, 0, 1250, 1350, 1450, 1550, 1650, 1650};

  initial begin
    int base;
    bus.valid_i = 1'b0; bus.distance_i = '0; bus.clear_i = 1'b0;
    model_reset();

    phase = "reset";
    apply_reset();

    // Back-to-back ramp: medians lag one sample, averages step by 100.
    phase = "ramp";
    for (int i = 0; i < 12; i++) begin
      tbl[i].v  = (i < 10);
      tbl[i].d  = (i < 10) ? 1000 + 100 * i : 0;
      tbl[i].c  = 0;
      tbl[i].ev = (i >= 6 && i <= 10);
      tbl[i].ed = ramp_exp[i];
      tbl[i].es = 0;
      tbl[i].eo = 0;
    end
    for (int i = 0; i < 12; i++) begin
      tick(tbl[i].v, tbl[i].d, tbl[i].c);
      n_vec++;
      if (bus.valid_o !== tbl[i].ev || bus.distance_o !== DW'(tbl[i].ed) ||
          bus.stable_o !== tbl[i].es || bus.outlier_o !== tbl[i].eo) begin
        n_miss++;
        $display("FAIL ramp row%0d: got v=%0b d=%0d s=%0b o=%0b, want v=%0b d=%0d s=%0b o=%0b",
                 i, bus.valid_o, bus.distance_o, bus.stable_o, bus.outlier_o,
                 tbl[i].ev, tbl[i].ed, tbl[i].es, tbl[i].eo);
      end
    end

    phase = "steady14";
    apply_reset();
    for (int k = 1; k <= 14; k++) begin
      step(1, 1000, 0);
      step(0, 0, 0);
      if (k < 6)  chk("warm_no_valid", 32'(bus.valid_o), 0);
      if (k == 6) begin
        chk("first_valid", 32'(bus.valid_o), 1);
        chk("first_dist",  32'(bus.distance_o), 1000);
      end
      if (k == 13) chk("stable_before_14", 32'(bus.stable_o), 0);
      if (k == 14) chk("stable_at_14",     32'(bus.stable_o), 1);
      idle(48);
    end

    phase = "spike";
    for (int k = 0; k < 6; k++) begin
      step(1, (k == 2) ? 5000 : 1000, 0);
      step(0, 0, 0);
      chk("spike_stable", 32'(bus.stable_o),   1);
      chk("spike_dist",   32'(bus.distance_o), 1000);
      idle(3);
    end

    phase = "outlier";
    step(1, 0, 0);
    chk("zero_outlier", 32'(bus.outlier_o), 1);
    chk("zero_novalid", 32'(bus.valid_o),   0);
    step(0, 0, 0);
    chk("outlier_one_cycle", 32'(bus.outlier_o), 0);
    step(1, 40000, 0);
    chk("far_outlier", 32'(bus.outlier_o), 1);
    idle(3);
    chk("outlier_dist_kept",   32'(bus.distance_o), 1000);
    chk("outlier_stable_kept", 32'(bus.stable_o),   1);

    phase = "flush";
    step(1, 1000, 0);
    idle(3);
    for (int k = 0; k < 4; k++) step(1, 0, 0);
    chk("flush_outlier", 32'(bus.outlier_o), 1);
    chk("flush_stable",  32'(bus.stable_o),  0);
    step(0, 0, 0);
    chk("flush_novalid", 32'(bus.valid_o),    0);
    chk("flush_hold",    32'(bus.distance_o), 1000);
    warm6(2000, "refill");

    phase = "clear";
    for (int k = 0; k < 8; k++) step(1, 2500, 0);
    step(1, 2600, 1);
    chk("clear_no_outlier", 32'(bus.outlier_o), 0);
    chk("clear_no_valid",   32'(bus.valid_o),   0);
    chk("clear_stable",     32'(bus.stable_o),  0);
    step(0, 0, 0);
    warm6(2700, "clear_rewarm");

    phase = "reset_mid";
    step(1, 3000, 0); step(1, 3000, 0); step(1, 3000, 0);
    apply_reset();
    warm6(3100, "rst_rewarm");

    phase = "random";
    base = 8000;
    for (int i = 0; i < 4000; i++) begin
      int r;
      int d;
      bit v;
      bit c;
      if ($urandom_range(0, 199) == 0) base = $urandom_range(100, 29000);
      if ($urandom_range(0, 249) == 0) begin
        for (int k = 0; k < 4; k++) step(1, 0, 0);
      end
      if ($urandom_range(0, 999) == 0) apply_reset();
      r = $urandom_range(0, 31);
      if (r == 0)      d = 0;
      else if (r == 1) d = 30001 + $urandom_range(0, 1000);
      else if (r == 2) d = 30000;
      else if (r == 3) d = 1;
      else if (r == 4) d = $urandom_range(1, 30000);
      else             d = base + $urandom_range(0, 24);
      v = ($urandom_range(0, 2) != 0);
      c = ($urandom_range(0, 299) == 0);
      step(v, d, c);
    end
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/distance_filter.md
DISTANCE_FILTER -- requirements
Module: distance_filter

Interface
REQ-001 SHALL have parameter DIST_W, default 17, the width of distance samples.
REQ-002 SHALL have parameter MAX_DIST, default 30000, the largest distance accepted as in-range.
REQ-003 SHALL have parameter TOL, default 20, the maximum difference between successive averages that still counts as steady.
REQ-004 SHALL have parameter STABLE_N, default 8, the number of consecutive steady outputs needed before stable_o asserts.
REQ-005 SHALL have parameter MISS_LIMIT, default 4, the number of consecutive rejected samples that forces a flush.
REQ-006 SHALL have port clk, input, 1 bit: the single clock.
REQ-007 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-008 SHALL have port valid_i, input, 1 bit: one-cycle pulse from the ultrasonic stage marking a new sample.
REQ-009 SHALL have port distance_i, input, DIST_W bits: the raw sample, qualified by valid_i.
REQ-010 SHALL have port clear_i, input, 1 bit: synchronous flush request from the controller.
REQ-011 SHALL have port valid_o, output, 1 bit: one-cycle pulse marking a filtered result toward the controller.
REQ-012 SHALL have port distance_o, output, DIST_W bits: filtered distance, held between valid_o pulses.
REQ-013 SHALL have port stable_o, output, 1 bit: high while the target reading is steady.
REQ-014 SHALL have port outlier_o, output, 1 bit: one-cycle pulse when a sample is rejected.

Function
REQ-015 SHALL reject any sample with valid_i=1 and either distance_i==0 or distance_i>MAX_DIST; a rejected sample is not stored, and outlier_o pulses in cycle N+1, where N is the valid_i cycle.
REQ-016 SHALL shift each accepted sample into a 3-entry raw window and, once 3 samples are held, register the median of the window (stage 1).
REQ-017 SHALL push each median into a 4-entry ring buffer and keep a (DIST_W+2)-bit running sum, updated as sum + new − evicted, with no overflow possible.
REQ-018 SHALL, once the ring buffer is full, drive distance_o = sum>>2 (truncated) and pulse valid_o in cycle N+2.
REQ-019 SHALL therefore produce its first valid_o on the 6th accepted sample after reset, clear, or flush; all earlier samples produce no output (warm-up).
REQ-020 SHALL accept valid_i on every cycle (back-to-back), at full throughput, with no backpressure.
REQ-021 SHALL keep the FSM states WARM (filling window/buffer), RUN (producing outputs) and FLUSH (one cycle, empties all storage and then returns to WARM).
REQ-022 SHALL count consecutive rejected samples, reset that count on any accepted sample, and enter FLUSH when the count reaches MISS_LIMIT.
REQ-023 SHALL, on each valid_o, compare the new average with the previous output: if |diff|<=TOL, increment a steady counter saturating at STABLE_N; otherwise set the counter to 0.
REQ-024 SHALL take the first output after warm-up as the reference for the comparison, with the counter at 0.
REQ-025 SHALL assert stable_o while the steady counter equals STABLE_N, and deassert it on the same cycle as a failing valid_o, on entering FLUSH, or on clear_i.
REQ-026 SHALL treat clear_i as FLUSH in the next cycle; if clear_i and valid_i occur in the same cycle, clear wins, the sample is discarded, and there is no outlier_o pulse.
REQ-027 SHALL, during FLUSH, hold distance_o at its last value and keep valid_o low.

Reset
REQ-028 SHALL, on reset, set valid_o=0, stable_o=0, outlier_o=0, distance_o=0, all windows, sums and counters to 0, and the FSM to WARM.
REQ-029 SHALL, on reset assertion mid-pipeline, discard all in-flight samples, with no valid_o after reset release until 6 new accepted samples.

Structure
REQ-030 SHALL place DIST_W, the FSM state enum and the ring depth (4) in the shared package dist_filter_pkg.
REQ-031 SHALL implement the median as the combinational sub-module distance_median3 (three DIST_W inputs, one output), instantiated once.

Verification
REQ-032 SHALL cover this scenario: 14 samples of 1000, one every 50 cycles -> first valid_o on the 6th sample with distance_o=1000; stable_o rises with the 14th sample's valid_o.
REQ-033 SHALL cover this scenario: steady 1000 stream with a single 5000 spike -> distance_o stays 1000, and stable_o does not drop.
REQ-034 SHALL cover this scenario: samples 0 and 40000 injected -> outlier_o pulses for each, with no change to valid_o or distance_o.
REQ-035 SHALL cover this scenario: 4 consecutive zero samples during RUN -> FLUSH, stable_o=0, and the next valid_o only after 6 new good samples.
REQ-036 SHALL cover this scenario: ramp 1000,1100,...,1900 back-to-back (valid_i every cycle) -> outputs every cycle from the 6th sample, each equal to floor(mean of the last 4 medians), with stable_o=0.
REQ-037 SHALL cover this scenario: clear_i coincident with valid_i, plus rst_n asserted mid-stream -> sample dropped, all outputs return to 0 per REQ-028, and warm-up restarts.
